// File: rtl/logic_sweep_ctrl.sv
// Self-test sequencer for the two-input basic-gate unit: applies 00,01,10,11,
// waits SETTLE_CYCLES, checks {x,y,z,w,v} against the golden truth table.
module logic_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [4:0] res,
  output logic       a_o,
  output logic       b_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [2:0] err_cnt,
  output logic [4:0] last_res
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       fail_mask_q, fail_mask_d;
  logic [2:0]       err_cnt_q, err_cnt_d;
  logic             pass_q, pass_d;
  logic [4:0]       last_res_q, last_res_d;
  logic [4:0]       golden;

  always_comb begin
    golden = 5'b00011;
    case (vec_q)
      2'd0: golden = 5'b00011;
      2'd1: golden = 5'b01110;
      2'd2: golden = 5'b01110;
      2'd3: golden = 5'b11000;
      default: golden = 5'b00011;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    fail_mask_d = fail_mask_q;
    err_cnt_d   = err_cnt_q;
    pass_d      = pass_q;
    last_res_d  = last_res_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d     = S_APPLY;
          vec_d       = '0;
          cnt_d       = '0;
          fail_mask_d = '0;
          err_cnt_d   = '0;
          pass_d      = 1'b0;
        end
      end
      S_APPLY: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = S_CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else begin
          last_res_d = res;
          if (res != golden) begin
            fail_mask_d[vec_q] = 1'b1;
            err_cnt_d          = err_cnt_q + 3'd1;
          end
          // pass is resolved on entry to DONE so it is valid alongside the done pulse
          if (vec_q == 2'd3) begin
            state_d = S_DONE;
            pass_d  = (err_cnt_d == 3'd0);
          end else begin
            vec_d   = vec_q + 2'd1;
            state_d = S_APPLY;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      cnt_q       <= '0;
      fail_mask_q <= '0;
      err_cnt_q   <= '0;
      pass_q      <= 1'b0;
      last_res_q  <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      fail_mask_q <= fail_mask_d;
      err_cnt_q   <= err_cnt_d;
      pass_q      <= pass_d;
      last_res_q  <= last_res_d;
    end
  end

  assign busy       = (state_q == S_APPLY) || (state_q == S_CHECK);
  assign done       = (state_q == S_DONE);
  assign a_o        = busy & vec_q[1];
  assign b_o        = busy & vec_q[0];
  assign pass       = pass_q;
  assign fail_mask  = fail_mask_q;
  assign err_cnt    = err_cnt_q;
  assign last_res   = last_res_q;

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Bench for logic_sweep_ctrl: a gate unit with injectable stuck-at faults and
// a truth-table reference model computed from the gate functions.
module tb_logic_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start1, abort1, start2;
  logic       abort2;
  logic [4:0] s0, s1;
  logic [4:0] res1, res2;
  logic       a1, b1, busy1, done1, pass1;
  logic       a2, b2, busy2, done2, pass2;
  logic [3:0] fm1, fm2;
  logic [2:0] ec1, ec2;
  logic [4:0] lr1, lr2;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  function automatic logic [4:0] gate(input logic a, input logic b);
    return {a & b, a | b, a ^ b, ~(a & b), ~(a | b)};
  endfunction

  assign res1   = (gate(a1, b1) & ~s0) | s1;
  assign res2   = gate(a2, b2);
  assign abort2 = 1'b0;

  logic_sweep_ctrl #(.SETTLE_CYCLES(2), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .res(res1),
    .a_o(a1), .b_o(b1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_mask(fm1), .err_cnt(ec1), .last_res(lr1)
  );

  logic_sweep_ctrl #(.SETTLE_CYCLES(1), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .res(res2),
    .a_o(a2), .b_o(b2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_mask(fm2), .err_cnt(ec2), .last_res(lr2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full S=2 sweep with faults f0 (stuck-at-0) / f1 (stuck-at-1); optional start re-pulses.
  task automatic sweep1(input logic [4:0] f0, input logic [4:0] f1, input bit repulse);
    logic [3:0] efm;
    logic [2:0] eec;
    logic [4:0] elr, good, bad;
    s0 = f0;
    s1 = f1;
    efm = '0;
    eec = '0;
    elr = '0;
    for (int v = 0; v < 4; v++) begin
      good = gate(v[1], v[0]);
      bad  = (good & ~f0) | f1;
      if (bad !== good) begin
        efm[v] = 1'b1;
        eec++;
      end
      if (v == 3) elr = bad;
    end
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk("busy", 32'(busy1), 32'd1);
      chk("done_early", 32'(done1), 32'd0);
      chk("ab_seq", 32'({a1, b1}), 32'(k / 3));
      start1 = repulse && (k == 2 || k == 6);
      step();
    end
    start1 = 1'b0;
    chk("done", 32'(done1), 32'd1);
    chk("busy_done", 32'(busy1), 32'd0);
    chk("ab_done", 32'({a1, b1}), 32'd0);
    chk("pass", 32'(pass1), 32'(eec == 3'd0));
    chk("fail_mask", 32'(fm1), 32'(efm));
    chk("err_cnt", 32'(ec1), 32'(eec));
    chk("last_res", 32'(lr1), 32'(elr));
    step();
    chk("done_pulse", 32'(done1), 32'd0);
    chk("pass_hold", 32'(pass1), 32'(eec == 3'd0));
    chk("mask_hold", 32'(fm1), 32'(efm));
  endtask

  initial begin
    logic [4:0] rf0, rf1;
    rst = 1'b1; start1 = 1'b0; abort1 = 1'b0; start2 = 1'b0;
    s0 = '0; s1 = '0;
    step();
    step();
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_ab", 32'({a1, b1}), 32'd0);
    chk("rst_pass", 32'(pass1), 32'd0);
    chk("rst_mask", 32'(fm1), 32'd0);
    chk("rst_err", 32'(ec1), 32'd0);
    chk("rst_lr", 32'(lr1), 32'd0);
    rst = 1'b0;
    step();

    sweep1(5'b00000, 5'b00000, 1'b0);
    sweep1(5'b00100, 5'b00000, 1'b0);
    sweep1(5'b00000, 5'b00000, 1'b1);

    // abort during vec1 APPLY with w stuck-at-1
    s0 = '0; s1 = 5'b00010;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    abort1 = 1'b1;
    step();
    abort1 = 1'b0;
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_ab", 32'({a1, b1}), 32'd0);
    chk("abort_pass", 32'(pass1), 32'd0);
    chk("abort_mask", 32'(fm1), 32'd0);
    chk("abort_err", 32'(ec1), 32'd0);
    chk("abort_lr", 32'(lr1), 32'(5'b00011));
    for (int k = 0; k < 4; k++) begin
      chk("abort_nodone", 32'(done1), 32'd0);
      step();
    end
    sweep1(5'b00000, 5'b00010, 1'b0);

    // reset mid-sweep
    sweep1(5'b00100, 5'b00000, 1'b0);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int k = 1; k <= 6; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_busy", 32'(busy1), 32'd0);
    chk("mrst_done", 32'(done1), 32'd0);
    chk("mrst_ab", 32'({a1, b1}), 32'd0);
    chk("mrst_pass", 32'(pass1), 32'd0);
    chk("mrst_mask", 32'(fm1), 32'd0);
    chk("mrst_err", 32'(ec1), 32'd0);
    chk("mrst_lr", 32'(lr1), 32'd0);
    step();
    sweep1(5'b00000, 5'b00000, 1'b0);

    // start and abort together in IDLE
    start1 = 1'b1;
    abort1 = 1'b1;
    step();
    chk("sa_busy", 32'(busy1), 32'd0);
    chk("sa_ab", 32'({a1, b1}), 32'd0);
    start1 = 1'b0;
    abort1 = 1'b0;
    step();
    chk("sa_busy2", 32'(busy1), 32'd0);
    chk("sa_done", 32'(done1), 32'd0);

    // randomized fault patterns and idle gaps
    for (int i = 0; i < 6; i++) begin
      rf0 = 5'($urandom);
      rf1 = 5'($urandom) & ~rf0;
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
      sweep1(rf0, rf1, 1'($urandom_range(0, 1)));
    end

    // SETTLE_CYCLES=1 instance
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("s1_busy", 32'(busy2), 32'd1);
      chk("s1_done_early", 32'(done2), 32'd0);
      chk("s1_ab", 32'({a2, b2}), 32'(k / 2));
      step();
    end
    chk("s1_done", 32'(done2), 32'd1);
    chk("s1_pass", 32'(pass2), 32'd1);
    chk("s1_mask", 32'(fm2), 32'd0);
    chk("s1_err", 32'(ec2), 32'd0);
    chk("s1_lr", 32'(lr2), 32'(5'b11000));
    step();
    chk("s1_done_pulse", 32'(done2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/logic_sweep_ctrl.md
Name: logic_sweep_ctrl

Overview:
- Self-test sequencer for the two-input basic-gate unit (inputs a, b; outputs x, y, z, w, v).
- On start, drives the unit through all four input combinations in order 00, 01, 10, 11.
- Waits a programmable settle time, samples the five outputs and compares them with the fixed golden truth table.
- Reports per-vector pass/fail, an error count and a done pulse. Sits between the test/config logic and the gate unit instance.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..15
CNT_W, 4, width of internal settle counter; must hold SETTLE_CYCLES-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  begin a sweep; sampled only in IDLE
abort  input  1  cancel a running sweep
res  input  5  gate unit outputs {x,y,z,w,v}; res[4]=x, res[0]=v
a_o  output  1  drive to gate unit input a
b_o  output  1  drive to gate unit input b
busy  output  1  high in APPLY/CHECK
done  output  1  one-cycle pulse at end of completed sweep
pass  output  1  1 = last completed sweep had zero mismatches
fail_mask  output  4  bit i set = vector i ({a,b}=i) mismatched
err_cnt  output  3  number of failing vectors, 0..4
last_res  output  5  res value captured in most recent CHECK

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high. All state updates on the rising clk edge.
- Reset values: state=IDLE, a_o=0, b_o=0, busy=0, done=0, pass=0, fail_mask=0, err_cnt=0, last_res=0, vec=0, cnt=0.
- Golden table {x,y,z,w,v}, meaning x=AND, y=OR, z=XOR, w=NAND, v=NOR:
  - vec0 (a=0,b=0) = 5'b00011
  - vec1 (0,1) = 5'b01110
  - vec2 (1,0) = 5'b01110
  - vec3 (1,1) = 5'b11000
- {a_o,b_o} = vec in APPLY and CHECK; 00 in IDLE and DONE.
- IDLE: on start=1 and abort=0, next state APPLY with vec=0, cnt=0, fail_mask=0, err_cnt=0, pass=0. Otherwise remain.
- APPLY: cnt increments each cycle. When cnt==SETTLE_CYCLES-1, next state CHECK and cnt=0. APPLY lasts exactly SETTLE_CYCLES cycles per vector.
- CHECK (one cycle):
  - Register last_res=res.
  - If res != golden[vec], set fail_mask[vec] and increment err_cnt.
  - If vec==3, next state DONE; else vec+1 and APPLY.
- DONE (one cycle): done=1, pass=(err_cnt==0), next state IDLE.
- Results hold until the next accepted start or rst.
- Timing: done rises on the 4*(SETTLE_CYCLES+1)-th edge after the edge that sampled start (S=2 gives 12; S=1 gives 8). No gap between vectors.
- start while busy or in DONE: ignored, no effect on the running sweep.
- abort=1 in APPLY/CHECK: next state IDLE, a_o=b_o=0, busy=0, pass=0, no done pulse. fail_mask, err_cnt and last_res keep partial values. A CHECK in the abort cycle does not update results.
- abort in DONE: ignored; done still pulses.
- start and abort both high in IDLE: abort wins, stay IDLE.
- rst mid-sweep: all outputs return to reset values on that edge; no done.
- res is sampled only in CHECK; activity on res in other states is ignored.

Test Plan:
- Correct gate model, S=2, pulse start at edge 0 -> {a_o,b_o} sequence 00,01,10,11 held 3 cycles each; done high at edge 12 for 1 cycle; pass=1; fail_mask=0000; err_cnt=0; last_res=11000.
- Gate model with z stuck-at-0 -> vec1/vec2 mismatch; fail_mask=0110, err_cnt=2, pass=0, last_res=11000.
- start re-pulsed at edges 3 and 7 of a running sweep -> sweep unaffected; done only at edge 12; exactly one done pulse.
- abort at edge 5 (vec1 APPLY) with w stuck-at-1 -> IDLE next edge; busy=0; no done; pass=0; fail_mask=0000. A new start then completes with fail_mask=1000, err_cnt=1.
- rst asserted at edge 7 -> all outputs equal reset values next cycle; a subsequent start runs a full normal sweep.
- SETTLE_CYCLES=1 instance, correct model -> each vector held 2 cycles; done at edge 8; pass=1. Separately, start and abort high together in IDLE -> stays IDLE, busy=0.
